ones_comp_serial_sub: RTL
=========================

# ones_comp_serial_sub

Bit-serial ones' complement add/subtract sequencer. It accepts two WIDTH-bit ones' complement operands through a start/busy/done handshake and time-multiplexes a single full adder to produce the result. Pass 1 forms A + B, or A + ~B when subtracting. Pass 2 folds the end-around carry back in. It sits beside the combinational ones' complement adder as the area-minimal alternative for the subtraction lab datapath.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request; sampled only in IDLE
- sub  input  1  1 = A − B, 0 = A + B; latched with operands
- NumA  input  WIDTH  operand A, latched on the accepting edge
- NumB  input  WIDTH  operand B, latched on the accepting edge
- busy  output  1  high from the accepting edge until the return to IDLE
- done  output  1  one-cycle pulse; Comp and flags are valid from this cycle on
- Comp  output  WIDTH  ones' complement result, held until the next accepted start
- neg  output  1  Comp[WIDTH-1]
- zero  output  1  Comp is all zeros or all ones (+0 or −0)
- ovf  output  1  signed overflow of pass 1 (see Operation)

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE → PASS1 on start=1. The accepting edge does the following:
  - latches a = NumA and b = sub ? ~NumB : NumB;
  - clears the bit index and the carry register.
- PASS1: one bit per cycle, LSB first.
  - Full adder inputs: a[i], b[i], carry.
  - The sum bit shifts into the sum register.
  - The carry register takes Cout.
  - After bit WIDTH−1, the final Cout is stored as eac (end-around carry), the carry register is loaded with eac, and the state moves to PASS2.
- PASS2: one bit per cycle.
  - Full adder inputs: sum[i], 0, carry.
  - The result shifts into Comp.
  - After bit WIDTH−1, the state moves to DONE.
  - PASS2 never generates a final carry out; the bench asserts this.
- DONE: done=1 for one cycle, then IDLE.
- ovf = (a[MSB] == b[MSB]) && (Comp[MSB] != a[MSB]). It is computed on entry to DONE.
- start is ignored in PASS1, PASS2 and DONE. No queuing.
- Input operand changes after the accepting edge have no effect.
- Reset, including mid-operation:
  - state returns to IDLE;
  - busy, done, Comp, neg, zero, ovf, eac, carry and the bit index all clear to 0;
  - no done pulse is produced for the aborted operation.

## Timing
- The accepting edge is t0, with start=1 in IDLE.
- busy=1 in the cycle after t0.
- Edges t0+1 … t0+WIDTH: PASS1 bits.
- Edges t0+WIDTH+1 … t0+2·WIDTH: PASS2 bits.
- After edge t0+2·WIDTH the state is DONE, so done=1 and the outputs are final.
- Edge t0+2·WIDTH+1 returns to IDLE with busy=0. The earliest next accepting edge is t0+2·WIDTH+1 itself if start=1 there? No: start is sampled only in IDLE, so the earliest next accepting edge is t0+2·WIDTH+2.
- Start-to-done latency is 2·WIDTH edges; throughput is one operation per 2·WIDTH+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared header/package ones_comp_pkg holds:
  - the state encoding constants (IDLE=2'd0, PASS1=2'd1, PASS2=2'd2, DONE=2'd3);
  - the default WIDTH.
- Sub-module: a single instance of the existing full_adder (Bit1, Bit2, Cin, Y, Cout), muxed between pass 1 and pass 2 operands.
- Bit index is $clog2(WIDTH) bits wide.
- Operand, sum and result storage are WIDTH-bit shift registers.

## Test plan
All cases use WIDTH=4.
- Subtract, positive result: sub=1, A=0101, B=0011.
  - Pass 1 gives 0001 with eac=1.
  - Expected: Comp=0010, neg=0, zero=0, ovf=0, done exactly 8 edges after acceptance.
- Subtract, negative result: sub=1, A=0011, B=0101.
  - Pass 1 gives 1101 with eac=0.
  - Expected: Comp=1101 (−2), neg=1, ovf=0.
- Negative zero: sub=1, A=0101, B=0101.
  - Expected: Comp=1111, zero=1, neg=1.
- Add, both negative: sub=0, A=1110, B=1110 (−1 + −1).
  - Expected: Comp=1101 (−2), ovf=0.
- Add, overflow: sub=0, A=0111, B=0001.
  - Expected: Comp=1000, ovf=1.
- start held high throughout, plus reset mid-run.
  - Expected: exactly one accept per 10 cycles.
  - Reset asserted at PASS2 bit 1 gives IDLE and all outputs 0 on the next edge, and no done pulse.
  - The next start then completes normally with a fresh result.

Source files
------------

// File: rtl/ones_comp_pkg.sv
// Shared definitions for the bit-serial ones' complement add/subtract sequencer.
// The state encoding and default width are common to the datapath and its bench.
package ones_comp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, time-multiplexed by the serial sequencer.
module full_adder (
    input  logic Bit1,
    input  logic Bit2,
    input  logic Cin,
    output logic Y,
    output logic Cout
);

    assign Y    = Bit1 ^ Bit2 ^ Cin;
    assign Cout = (Bit1 & Bit2) | (Cin & (Bit1 ^ Bit2));

endmodule

// File: rtl/ones_comp_serial_sub.sv
// Bit-serial ones' complement add/subtract: pass 1 forms A + B (or A + ~B),
// pass 2 folds the end-around carry back in, both through one full adder.
module ones_comp_serial_sub
    import ones_comp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] NumA,
    input  logic [WIDTH-1:0] NumB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Comp,
    output logic             neg,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned  IW   = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_comp;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_eac;
    logic             r_busy;
    logic             r_done;
    logic             r_neg;
    logic             r_zero;
    logic             r_ovf;

    logic             w_last;
    logic             w_bit1;
    logic             w_bit2;
    logic             w_cin;
    logic             w_y;
    logic             w_cout;
    logic [WIDTH-1:0] w_comp_next;

    full_adder u_fa (
        .Bit1 (w_bit1),
        .Bit2 (w_bit2),
        .Cin  (w_cin),
        .Y    (w_y),
        .Cout (w_cout)
    );

    always_comb begin
        w_next = r_state;
        w_last = (r_idx == LAST);
        unique case (r_state)
            IDLE:  if (start)  w_next = PASS1;
            PASS1: if (w_last) w_next = PASS2;
            PASS2: if (w_last) w_next = DONE;
            DONE:              w_next = IDLE;
            default:           w_next = IDLE;
        endcase
    end

    // Operands rotate rather than shift so their MSBs are intact for ovf at the end.
    always_comb begin
        w_bit1 = r_sum[0];
        w_bit2 = 1'b0;
        w_cin  = r_carry;
        if (r_state == PASS1) begin
            w_bit1 = r_a[0];
            w_bit2 = r_b[0];
        end else if (r_state == PASS2 && r_idx == '0) begin
            w_cin = r_eac;
        end
        w_comp_next = {w_y, r_comp[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_comp  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_eac   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= NumA;
                        r_b     <= sub ? ~NumB : NumB;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                PASS1: begin
                    r_a     <= {r_a[0], r_a[WIDTH-1:1]};
                    r_b     <= {r_b[0], r_b[WIDTH-1:1]};
                    r_sum   <= {w_y, r_sum[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) r_eac <= w_cout;
                end
                PASS2: begin
                    r_sum   <= {r_sum[0], r_sum[WIDTH-1:1]};
                    r_comp  <= w_comp_next;
                    r_carry <= w_cout;
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) begin
                        r_done <= 1'b1;
                        r_neg  <= w_comp_next[WIDTH-1];
                        r_zero <= (w_comp_next == '0) || (w_comp_next == '1);
                        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                  (w_comp_next[WIDTH-1] != r_a[WIDTH-1]);
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Comp = r_comp;
    assign neg  = r_neg;
    assign zero = r_zero;
    assign ovf  = r_ovf;

endmodule
